spi_flash_ctl: RTL and testbench

Hardware SPI master that takes over sequencing of the configuration-flash pins (SCK, MOSI, MISO, CS), replacing per-bit toggling through the misc.out port with whole-byte transfers issued from the j1 I/O space. It also arbitrates the pins between its own byte engine and the legacy bit-bang path, so existing firmware keeps working. It sits beside the UART and GPIO ports in `top`, fed by the registered I/O strobes (`io_wr_`, `io_rd_`, `dout_`) and an address-bit decode.

---
 rtl/spi_flash_pkg.sv | 25 ++
 rtl/spi_flash_ctl_shift8.sv | 24 ++
 rtl/spi_flash_ctl.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_ctl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash controller: FSM encoding, status bit
// positions and counter widths.
package spi_flash_pkg;

  localparam int DIV_W   = 8;
  localparam int CNT_W   = 3;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOW  = 2'd1;
  localparam logic [STATE_W-1:0] ST_HIGH = 2'd2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_OWNER_BB = 2;
  localparam int STAT_OVERRUN  = 3;

  localparam logic [CNT_W-1:0] LAST_BIT = 3'd7;

  // Value loaded into the divider so that a phase lasts clkdiv cycles
  function automatic logic [DIV_W-1:0] div_reload(input int clkdiv);
    return DIV_W'(clkdiv - 1);
  endfunction

endpackage

// File: rtl/spi_flash_ctl_shift8.sv
// 8-bit load / shift-left register; MSB is the outgoing bit, serial_in
// enters at bit 0.
module spi_shift8 (
  input  logic       clk,
  input  logic       resetq,
  input  logic       load,
  input  logic       shift_en,
  input  logic [7:0] load_data,
  input  logic       serial_in,
  output logic [7:0] q
);

  // Load has priority so a back-to-back transfer can start on the last shift
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[6:0], serial_in};
    end
  end

endmodule

// File: rtl/spi_flash_ctl.sv
// SPI mode-0 byte engine for the configuration flash, with a pin arbiter that
// hands the flash pins to the legacy bit-bang path on request.
module spi_flash_ctl #(
  parameter int CLKDIV = 1
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       data_wr,
  input  logic       ctl_wr,
  input  logic       stat_rd,
  input  logic [7:0] wd,
  output logic [7:0] rx_data,
  output logic [3:0] status,
  input  logic       bb_sck,
  input  logic       bb_mosi,
  input  logic       bb_csn,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       csn
);

  import spi_flash_pkg::*;

  localparam logic [DIV_W-1:0] DIV_RELOAD = div_reload(CLKDIV);

  logic [STATE_W-1:0] state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic               sck_q, sck_nxt;
  logic               mosi_q, mosi_nxt;
  logic               busy_q;
  logic               csn_q;
  logic               bb_req;
  logic               owner_bb;
  logic               rx_valid;
  logic               overrun;
  logic [7:0]         shift_q;
  logic               load;
  logic               shift_en;
  logic               complete;
  logic               can_start;
  logic               phase_end;
  logic               drop;

  // A new byte may only start when the engine owns the pins and no hand-over
  // to the bit-bang path is waiting
  assign can_start = !owner_bb && !bb_req;
  assign phase_end = (div_cnt == '0);
  assign drop      = data_wr && !load;

  spi_shift8 u_shift (
    .clk       (clk),
    .resetq    (resetq),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (wd),
    .serial_in (miso),
    .q         (shift_q)
  );

  // Next-state logic: divider pacing, bit sequencing and registered pin values
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    cnt_nxt   = bit_cnt;
    sck_nxt   = sck_q;
    mosi_nxt  = mosi_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_wr && can_start) begin
          load      = 1'b1;
          state_nxt = ST_LOW;
          div_nxt   = DIV_RELOAD;
          cnt_nxt   = LAST_BIT;
          sck_nxt   = 1'b0;
          mosi_nxt  = wd[7];
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          state_nxt = ST_HIGH;
          div_nxt   = DIV_RELOAD;
          sck_nxt   = 1'b1;
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          shift_en = 1'b1;
          div_nxt  = DIV_RELOAD;
          sck_nxt  = 1'b0;
          if (bit_cnt == '0) begin
            complete = 1'b1;
            if (data_wr && can_start) begin
              load      = 1'b1;
              state_nxt = ST_LOW;
              cnt_nxt   = LAST_BIT;
              mosi_nxt  = wd[7];
            end else begin
              state_nxt = ST_IDLE;
              mosi_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt   = bit_cnt - CNT_W'(1);
            state_nxt = ST_LOW;
            mosi_nxt  = shift_q[6];
          end
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        sck_nxt   = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

  // Engine state and registered SCK/MOSI; reset aborts any transfer at once
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= cnt_nxt;
      sck_q   <= sck_nxt;
      mosi_q  <= mosi_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  // Control register: chip select takes effect immediately, bb_req is latched
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      csn_q  <= 1'b1;
      bb_req <= 1'b0;
    end else if (ctl_wr) begin
      csn_q  <= ~wd[0];
      bb_req <= wd[1];
    end
  end

  // Pin ownership only changes hands while the engine is idle
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      owner_bb <= 1'b0;
    end else if (state == ST_IDLE) begin
      owner_bb <= bb_req;
    end
  end

  // Receive data and sticky flags; fresh data beats a coincident status read
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (complete) begin
        rx_data <= {shift_q[6:0], miso};
      end
      rx_valid <= complete | (rx_valid & ~stat_rd);
      if (drop || (complete && rx_valid && !stat_rd)) begin
        overrun <= 1'b1;
      end else if (stat_rd) begin
        overrun <= 1'b0;
      end
    end
  end

  // Status word assembled from the individual flags
  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = busy_q;
    status[STAT_RX_VALID] = rx_valid;
    status[STAT_OWNER_BB] = owner_bb;
    status[STAT_OVERRUN]  = overrun;
  end

  assign sck  = owner_bb ? bb_sck  : sck_q;
  assign mosi = owner_bb ? bb_mosi : mosi_q;
  assign csn  = owner_bb ? bb_csn  : csn_q;

endmodule

// File: tb/tb_spi_flash_ctl.sv
// Bench for spi_flash_ctl: one instance at CLKDIV=1 with MOSI looped back to
// MISO, one at CLKDIV=3 with MISO driven by the bench, both compared against
// a cycle-count based model of the byte engine.
module tb_spi_flash_ctl;

  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  typedef struct packed {
    bit       busy;
    int       k;
    bit [7:0] tx;
    bit [7:0] sh_in;
    bit [7:0] rx_data;
    bit       rx_valid;
    bit       overrun;
    bit       owner_bb;
    bit       bb_req;
    bit       cs_assert;
  } model_t;

  typedef struct packed {
    logic       sck;
    logic       mosi;
    logic       csn;
    logic [3:0] status;
    logic [7:0] rx;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetq = 1'b1;
  logic       data_wr [2];
  logic       ctl_wr [2];
  logic       stat_rd [2];
  logic [7:0] wd [2];
  logic       bb_sck, bb_mosi, bb_csn;
  logic       miso0, miso1;
  logic [7:0] rx_w [2];
  logic [3:0] status_w [2];
  logic       sck_w [2];
  logic       mosi_w [2];
  logic       csn_w [2];

  model_t     m [2];
  int         tests = 0;
  int         fails = 0;
  bit         rand_miso = 1'b0;
  logic [7:0] miso_pat = 8'h00;
  int         cyc;
  bit         drained;

  always #5 clk = ~clk;

  assign miso0 = mosi_w[0];

  spi_flash_ctl #(.CLKDIV(DIV0)) u_dut0 (
    .clk(clk), .resetq(resetq), .data_wr(data_wr[0]), .ctl_wr(ctl_wr[0]),
    .stat_rd(stat_rd[0]), .wd(wd[0]), .rx_data(rx_w[0]), .status(status_w[0]),
    .bb_sck(bb_sck), .bb_mosi(bb_mosi), .bb_csn(bb_csn), .miso(miso0),
    .sck(sck_w[0]), .mosi(mosi_w[0]), .csn(csn_w[0])
  );

  spi_flash_ctl #(.CLKDIV(DIV1)) u_dut1 (
    .clk(clk), .resetq(resetq), .data_wr(data_wr[1]), .ctl_wr(ctl_wr[1]),
    .stat_rd(stat_rd[1]), .wd(wd[1]), .rx_data(rx_w[1]), .status(status_w[1]),
    .bb_sck(bb_sck), .bb_mosi(bb_mosi), .bb_csn(bb_csn), .miso(miso1),
    .sck(sck_w[1]), .mosi(mosi_w[1]), .csn(csn_w[1])
  );

  // Pin and status values implied by the model: k counts edges since accept
  function automatic exp_t exp_out(model_t mm, int d, logic bs, logic bm, logic bc);
    exp_t e;
    int   bit_idx;
    bit_idx  = 7 - (mm.k / (2 * d));
    e.sck    = mm.owner_bb ? bs : (mm.busy && ((mm.k % (2 * d)) >= d));
    e.mosi   = mm.owner_bb ? bm : (mm.busy ? mm.tx[bit_idx] : 1'b0);
    e.csn    = mm.owner_bb ? bc : ~mm.cs_assert;
    e.status = {mm.overrun, mm.owner_bb, mm.rx_valid, mm.busy};
    e.rx     = mm.rx_data;
    return e;
  endfunction

  // One clock edge of the model, using the inputs as they were before the edge
  function automatic model_t step(model_t mm, int d, logic dw, logic cw, logic sr,
                                  logic [7:0] wv, logic mi);
    model_t n;
    bit     sample, complete, accept;
    n        = mm;
    sample   = mm.busy && (((mm.k + 1) % (2 * d)) == 0);
    complete = mm.busy && ((mm.k + 1) == 16 * d);
    accept   = dw && !mm.owner_bb && !mm.bb_req && (!mm.busy || complete);
    if (sample) n.sh_in[8 - ((mm.k + 1) / (2 * d))] = mi;
    if (!mm.busy) n.owner_bb = mm.bb_req;
    if (cw) begin
      n.cs_assert = wv[0];
      n.bb_req    = wv[1];
    end
    if (sr) begin
      n.rx_valid = 1'b0;
      n.overrun  = 1'b0;
    end
    if (dw && !accept) n.overrun = 1'b1;
    if (complete) begin
      n.rx_data = n.sh_in;
      if (mm.rx_valid && !sr) n.overrun = 1'b1;
      n.rx_valid = 1'b1;
    end
    if (accept) begin
      n.busy  = 1'b1;
      n.k     = 0;
      n.tx    = wv;
      n.sh_in = '0;
    end else if (complete) begin
      n.busy = 1'b0;
    end else if (mm.busy) begin
      n.k = mm.k + 1;
    end
    return n;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Model advances on every clock edge and resets with the DUT
  always @(posedge clk or negedge resetq) begin : model_proc
    exp_t e0;
    if (!resetq) begin
      m[0] = '0;
      m[1] = '0;
    end else begin
      e0   = exp_out(m[0], DIV0, bb_sck, bb_mosi, bb_csn);
      m[0] = step(m[0], DIV0, data_wr[0], ctl_wr[0], stat_rd[0], wd[0], e0.mosi);
      m[1] = step(m[1], DIV1, data_wr[1], ctl_wr[1], stat_rd[1], wd[1], miso1);
    end
  end

  // Compare every output of both instances on the falling edge
  always @(negedge clk) begin : cmp_proc
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = exp_out(m[i], (i == 0) ? DIV0 : DIV1, bb_sck, bb_mosi, bb_csn);
      check_output($sformatf("sck%0d", i), 32'(sck_w[i]), 32'(e.sck));
      check_output($sformatf("mosi%0d", i), 32'(mosi_w[i]), 32'(e.mosi));
      check_output($sformatf("csn%0d", i), 32'(csn_w[i]), 32'(e.csn));
      check_output($sformatf("status%0d", i), 32'(status_w[i]), 32'(e.status));
      check_output($sformatf("rx_data%0d", i), 32'(rx_w[i]), 32'(e.rx));
    end
  end

  // Advance one cycle, drop all strobes and refresh the background inputs
  task automatic apply_stimulus();
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      data_wr[i] = 1'b0;
      ctl_wr[i]  = 1'b0;
      stat_rd[i] = 1'b0;
    end
    bb_sck  = 1'($urandom);
    bb_mosi = 1'($urandom);
    bb_csn  = 1'($urandom);
    if (rand_miso) miso1 = 1'($urandom);
  endtask

  // Count busy cycles until the transfer ends; instance 1 gets miso_pat bits
  task automatic run_busy(input int idx, input int d, input int start, output int cycles);
    cycles = start;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!status_w[idx][0]) break;
      if (idx == 1 && cycles < 16 * d) miso1 = miso_pat[7 - cycles / (2 * d)];
      cycles++;
    end
    if (status_w[idx][0]) check_output("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      data_wr[i] = 1'b0;
      ctl_wr[i]  = 1'b0;
      stat_rd[i] = 1'b0;
      wd[i]      = 8'h00;
    end
    bb_sck  = 1'b0;
    bb_mosi = 1'b0;
    bb_csn  = 1'b1;
    miso1   = 1'b0;
    #1 resetq = 1'b0;
    repeat (3) apply_stimulus();
    #1;
    check_output("reset_sck", 32'(sck_w[0]), 32'd0);
    check_output("reset_mosi", 32'(mosi_w[0]), 32'd0);
    check_output("reset_csn", 32'(csn_w[0]), 32'd1);
    check_output("reset_status", 32'(status_w[0]), 32'd0);
    check_output("reset_rx", 32'(rx_w[0]), 32'd0);
    resetq = 1'b1;

    // Assert chip select on both instances
    apply_stimulus();
    ctl_wr[0] = 1'b1; wd[0] = 8'h01;
    ctl_wr[1] = 1'b1; wd[1] = 8'h01;
    apply_stimulus();

    // 0x9F with loopback at CLKDIV=1
    data_wr[0] = 1'b1; wd[0] = 8'h9F;
    apply_stimulus();
    run_busy(0, DIV0, 0, cyc);
    check_output("busy_cycles_div1", 32'(cyc), 32'd16);
    check_output("rx_9f", 32'(rx_w[0]), 32'h9F);
    check_output("status_after_9f", 32'(status_w[0]), 32'b0010);

    // CLKDIV=3 receiving 0xA5 from MISO
    data_wr[1] = 1'b1; wd[1] = 8'h5A;
    miso_pat = 8'hA5;
    apply_stimulus();
    run_busy(1, DIV1, 0, cyc);
    check_output("busy_cycles_div3", 32'(cyc), 32'd48);
    check_output("rx_a5", 32'(rx_w[1]), 32'hA5);

    // Second write five cycles into a transfer is dropped
    data_wr[1] = 1'b1; wd[1] = 8'h11;
    miso_pat = 8'hC3;
    apply_stimulus();
    repeat (4) apply_stimulus();
    data_wr[1] = 1'b1; wd[1] = 8'hEE;
    apply_stimulus();
    run_busy(1, DIV1, 5, cyc);
    check_output("busy_cycles_overrun", 32'(cyc), 32'd48);
    check_output("rx_c3", 32'(rx_w[1]), 32'hC3);
    check_output("overrun_set", 32'(status_w[1][3]), 32'd1);
    stat_rd[1] = 1'b1;
    apply_stimulus();
    #1 check_output("stat_rd_clears", 32'(status_w[1]), 32'b0000);

    // Bit-bang request mid-transfer is deferred until the engine is idle
    data_wr[0] = 1'b1; wd[0] = 8'h66;
    apply_stimulus();
    repeat (2) apply_stimulus();
    ctl_wr[0] = 1'b1; wd[0] = 8'h03;
    apply_stimulus();
    run_busy(0, DIV0, 3, cyc);
    check_output("busy_cycles_bbreq", 32'(cyc), 32'd16);
    check_output("rx_66", 32'(rx_w[0]), 32'h66);
    apply_stimulus();
    #1 check_output("owner_bb_set", 32'(status_w[0][2]), 32'd1);
    data_wr[0] = 1'b1; wd[0] = 8'hFF;
    apply_stimulus();
    #1;
    check_output("bb_write_overrun", 32'(status_w[0][3]), 32'd1);
    check_output("bb_sck_follows", 32'(sck_w[0]), 32'(bb_sck));
    check_output("bb_csn_follows", 32'(csn_w[0]), 32'(bb_csn));
    ctl_wr[0] = 1'b1; wd[0] = 8'h01;
    repeat (3) apply_stimulus();

    // Completion coincident with a status read
    data_wr[0] = 1'b1; wd[0] = 8'h42;
    apply_stimulus();
    repeat (15) apply_stimulus();
    stat_rd[0] = 1'b1;
    apply_stimulus();
    #1;
    check_output("coincident_status", 32'(status_w[0]), 32'b0010);
    check_output("coincident_rx", 32'(rx_w[0]), 32'h42);

    // Randomised traffic on both instances
    rand_miso = 1'b1;
    for (int n = 0; n < 600; n++) begin
      apply_stimulus();
      for (int i = 0; i < 2; i++) begin
        wd[i] = 8'($urandom);
        if ($urandom_range(0, 7) == 0) data_wr[i] = 1'b1;
        if ($urandom_range(0, 15) == 0) stat_rd[i] = 1'b1;
        if ($urandom_range(0, 39) == 0) ctl_wr[i] = 1'b1;
      end
    end

    // Return both instances to engine ownership and wait until idle
    apply_stimulus();
    ctl_wr[0] = 1'b1; wd[0] = 8'h01;
    ctl_wr[1] = 1'b1; wd[1] = 8'h01;
    drained = 1'b0;
    for (int n = 0; n < 300; n++) begin
      apply_stimulus();
      if (!m[0].busy && !m[1].busy && !m[0].owner_bb && !m[1].owner_bb) begin
        drained = 1'b1;
        break;
      end
    end
    check_output("drain", 32'(drained), 32'd1);

    // Reset during the high phase of the fourth bit at CLKDIV=3
    data_wr[1] = 1'b1; wd[1] = 8'h77;
    apply_stimulus();
    repeat (22) apply_stimulus();
    #1 resetq = 1'b0;
    #1;
    check_output("abort_csn", 32'(csn_w[1]), 32'd1);
    check_output("abort_sck", 32'(sck_w[1]), 32'd0);
    check_output("abort_status", 32'(status_w[1]), 32'd0);
    check_output("abort_rx", 32'(rx_w[1]), 32'd0);
    @(negedge clk);
    #1 resetq = 1'b1;

    // Fresh 0x3C transfers after reset
    rand_miso = 1'b0;
    apply_stimulus();
    ctl_wr[0] = 1'b1; wd[0] = 8'h01;
    ctl_wr[1] = 1'b1; wd[1] = 8'h01;
    apply_stimulus();
    data_wr[0] = 1'b1; wd[0] = 8'h3C;
    data_wr[1] = 1'b1; wd[1] = 8'h3C;
    miso_pat = 8'h3C;
    apply_stimulus();
    run_busy(1, DIV1, 0, cyc);
    check_output("busy_cycles_post_reset", 32'(cyc), 32'd48);
    check_output("rx0_3c", 32'(rx_w[0]), 32'h3C);
    check_output("rx1_3c", 32'(rx_w[1]), 32'h3C);
    repeat (2) apply_stimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
